truth_table_sweeper: RTL

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

---
 rtl/truth_table_sweeper.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/truth_table_sweeper.sv
// Exhaustive 4-input truth-table sweeper: applies all 16 vectors, waits SETTLE
// cycles per vector, captures f_a and counts f_a/f_b disagreements.
module truth_table_sweeper #(
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        f_a,
  input  logic        f_b,
  output logic [3:0]  vec,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] table_a,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  first_bad,
  output logic        first_bad_vld
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [3:0]  vec_q, vec_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] table_q, table_d;
  logic [4:0]  mcnt_q, mcnt_d;
  logic [3:0]  fb_q, fb_d;
  logic        fbv_q, fbv_d;
  logic        pass_q, pass_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  // State and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= 4'd0;
      cnt_q   <= 4'd0;
      table_q <= 16'h0000;
      mcnt_q  <= 5'd0;
      fb_q    <= 4'd0;
      fbv_q   <= 1'b0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      table_q <= table_d;
      mcnt_q  <= mcnt_d;
      fb_q    <= fb_d;
      fbv_q   <= fbv_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and result update logic
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    table_d = table_q;
    mcnt_d  = mcnt_q;
    fb_d    = fb_q;
    fbv_d   = fbv_q;
    pass_d  = pass_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETTLE;
          vec_d   = 4'd0;
          cnt_d   = 4'd0;
          table_d = 16'h0000;
          mcnt_d  = 5'd0;
          fb_d    = 4'd0;
          fbv_d   = 1'b0;
          pass_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = S_SAMPLE;
          cnt_d   = cnt_q + 4'd1;
        end else begin
          cnt_d   = cnt_q + 4'd1;
        end
      end
      S_SAMPLE: begin
        // Abort wins over the sample write so partial results stop at the last full vector
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          table_d[vec_q] = f_a;
          if (f_a != f_b) begin
            mcnt_d = mcnt_q + 5'd1;
            if (!fbv_q) begin
              fb_d  = vec_q;
              fbv_d = 1'b1;
            end else begin
              fbv_d = fbv_q;
            end
          end else begin
            mcnt_d = mcnt_q;
          end
          if (vec_q != 4'd15) begin
            vec_d   = vec_q + 4'd1;
            cnt_d   = 4'd0;
            state_d = S_SETTLE;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        pass_d  = (mcnt_q == 5'd0);
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign vec           = vec_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign table_a       = table_q;
  assign mismatch_cnt  = mcnt_q;
  assign first_bad     = fb_q;
  assign first_bad_vld = fbv_q;

endmodule
